// File: rtl/armleobus_lfsr_memory_if.sv
// armleobus request/response bundle between one initiator (master) and one
// responder (slave); clock and reset travel as plain ports alongside it.
interface armleobus_lfsr_memory_if;
  // Handshake: the master raises transaction with cmd/address/wdata/wbyte_enable
  // stable and holds it until the slave pulses transaction_done for one cycle;
  // transaction_response (and rdata for a successful read) are valid only in
  // that cycle. Still holding transaction in the done cycle requests a new beat.
  logic        transaction;
  logic [2:0]  cmd;
  logic [33:0] address;
  logic [3:0]  burstcount;
  logic [31:0] wdata;
  logic [3:0]  wbyte_enable;
  logic        transaction_done;
  logic [2:0]  transaction_response;
  logic [31:0] rdata;

  modport master (
    output transaction, cmd, address, burstcount, wdata, wbyte_enable,
    input  transaction_done, transaction_response, rdata
  );

  modport slave (
    input  transaction, cmd, address, burstcount, wdata, wbyte_enable,
    output transaction_done, transaction_response, rdata
  );
endinterface

// File: rtl/armleobus_lfsr_memory.sv
// Word-addressed armleobus memory target with LFSR-driven wait states and an
// optional error window, used to stress initiator timing and error handling.
module armleobus_lfsr_memory #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          MIN_WAIT   = 0,
  parameter logic [3:0]  WAIT_MASK  = 4'hF,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          ERR_BASE   = 0,
  parameter int          ERR_SIZE   = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  armleobus_lfsr_memory_if.slave      bus,
  output logic [1:0]                  dbg_state
);

  localparam logic [2:0] CMD_READ          = 3'd1;
  localparam logic [2:0] CMD_WRITE         = 3'd2;
  localparam logic [2:0] RESP_SUCCESS      = 3'd0;
  localparam logic [2:0] RESP_INVALID_OP   = 3'd1;
  localparam logic [2:0] RESP_MISSALIGNED  = 3'd2;
  localparam logic [2:0] RESP_UNKNOWN_ADDR = 3'd3;

  localparam int          IW        = DEPTH_LOG2 + 1;
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // Window bounds carry one extra bit so ERR_BASE+ERR_SIZE can reach 2^DEPTH_LOG2.
  localparam logic [IW-1:0] ERR_LO  = IW'(ERR_BASE);
  localparam logic [IW-1:0] ERR_HI  = IW'(ERR_BASE + ERR_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [15:0] lfsr, lfsr_n, lfsr_adv;
  logic [4:0]  wait_load;
  logic        accept;

  logic [2:0]  req_cmd;
  logic [33:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        done;
  logic [2:0]  resp;
  logic [31:0] rdata;

  logic [2:0]            dec_resp;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  in_window;
  logic                  wr_en;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic unused_bits;
  assign unused_bits = ^bus.burstcount;

  assign lfsr_adv  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign wait_load = 5'(MIN_WAIT) + {1'b0, lfsr[3:0] & WAIT_MASK};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lfsr_n  = lfsr;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.transaction) begin
          accept  = 1'b1;
          cnt_n   = wait_load;
          lfsr_n  = lfsr_adv;
          state_n = (wait_load != 5'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        // A dropped request abandons the beat silently.
        if (!bus.transaction) begin
          state_n = ST_IDLE;
          cnt_n   = 5'd0;
        end else if (cnt == 5'd1) begin
          state_n = ST_RESP;
          cnt_n   = 5'd0;
        end else begin
          cnt_n   = cnt - 5'd1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign word_idx  = req_addr[DEPTH_LOG2+1:2];
  assign in_window = (ERR_SIZE != 0) && ({1'b0, word_idx} >= ERR_LO) &&
                     ({1'b0, word_idx} < ERR_HI);

  always_comb begin
    dec_resp = RESP_SUCCESS;
    if (req_cmd != CMD_READ && req_cmd != CMD_WRITE)
      dec_resp = RESP_INVALID_OP;
    else if (req_addr[1:0] != 2'b00)
      dec_resp = RESP_MISSALIGNED;
    else if (req_addr[33:DEPTH_LOG2+2] != '0)
      dec_resp = RESP_UNKNOWN_ADDR;
    else if (in_window)
      dec_resp = RESP_UNKNOWN_ADDR;
  end

  assign wr_en = (state == ST_RESP) && (dec_resp == RESP_SUCCESS) && (req_cmd == CMD_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 5'd0;
      lfsr      <= LFSR_INIT;
      req_cmd   <= 3'd0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      done      <= 1'b0;
      resp      <= RESP_SUCCESS;
      rdata     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lfsr  <= lfsr_n;
      if (accept) begin
        req_cmd   <= bus.cmd;
        req_addr  <= bus.address;
        req_wdata <= bus.wdata;
        req_be    <= bus.wbyte_enable;
      end
      done <= (state == ST_RESP);
      if (state == ST_RESP) begin
        resp <= dec_resp;
        if (dec_resp == RESP_SUCCESS && req_cmd == CMD_READ)
          rdata <= mem[word_idx];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign bus.transaction_done     = done;
  assign bus.transaction_response = resp;
  assign bus.rdata                = rdata;
  assign dbg_state                = state;

endmodule

// File: tb/tb_armleobus_lfsr_memory.sv
// Directed bench for armleobus_lfsr_memory: three instances (fixed latency with
// error window, default random waits, fixed 5-cycle waits) on one clock.
module tb_armleobus_lfsr_memory;

  localparam logic [2:0] RD = 3'd1;
  localparam logic [2:0] WR = 3'd2;
  localparam logic [2:0] OK = 3'd0;
  localparam logic [2:0] INV = 3'd1;
  localparam logic [2:0] MIS = 3'd2;
  localparam logic [2:0] UNK = 3'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n_v;
  logic [2:0]  txn_v;
  logic [2:0]  cmd;
  logic [33:0] address;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [2:0]  done_v;
  logic [2:0]  resp_v  [3];
  logic [31:0] rdata_v [3];
  logic [1:0]  st_v    [3];

  int n_checks = 0;
  int n_fail   = 0;
  int          last_lat;
  logic [2:0]  last_resp;
  logic [31:0] last_rd;
  logic [31:0] exp_q[$];

  armleobus_lfsr_memory_if bus_fix ();
  armleobus_lfsr_memory_if bus_rnd ();
  armleobus_lfsr_memory_if bus_slow ();

  assign bus_fix.transaction  = txn_v[0];
  assign bus_rnd.transaction  = txn_v[1];
  assign bus_slow.transaction = txn_v[2];
  assign bus_fix.cmd = cmd;            assign bus_rnd.cmd = cmd;            assign bus_slow.cmd = cmd;
  assign bus_fix.address = address;    assign bus_rnd.address = address;    assign bus_slow.address = address;
  assign bus_fix.burstcount = 4'd0;    assign bus_rnd.burstcount = 4'd0;    assign bus_slow.burstcount = 4'd0;
  assign bus_fix.wdata = wdata;        assign bus_rnd.wdata = wdata;        assign bus_slow.wdata = wdata;
  assign bus_fix.wbyte_enable = be;    assign bus_rnd.wbyte_enable = be;    assign bus_slow.wbyte_enable = be;
  assign done_v = {bus_slow.transaction_done, bus_rnd.transaction_done, bus_fix.transaction_done};
  assign resp_v[0] = bus_fix.transaction_response;
  assign resp_v[1] = bus_rnd.transaction_response;
  assign resp_v[2] = bus_slow.transaction_response;
  assign rdata_v[0] = bus_fix.rdata;
  assign rdata_v[1] = bus_rnd.rdata;
  assign rdata_v[2] = bus_slow.rdata;

  armleobus_lfsr_memory #(.MIN_WAIT(0), .WAIT_MASK(4'h0), .ERR_BASE(16), .ERR_SIZE(4)) u_fix (
    .clk(clk), .rst_n(rst_n_v[0]), .bus(bus_fix), .dbg_state(st_v[0]));
  armleobus_lfsr_memory u_rnd (
    .clk(clk), .rst_n(rst_n_v[1]), .bus(bus_rnd), .dbg_state(st_v[1]));
  armleobus_lfsr_memory #(.MIN_WAIT(5), .WAIT_MASK(4'h0)) u_slow (
    .clk(clk), .rst_n(rst_n_v[2]), .bus(bus_slow), .dbg_state(st_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge inside the done cycle with
  // transaction already dropped so the target does not start another beat.
  task automatic beat(input int d, input logic [2:0] c, input logic [33:0] a,
                      input logic [31:0] wd, input logic [3:0] b);
    cmd = c; address = a; wdata = wd; be = b;
    txn_v[d] = 1'b1;
    last_lat = -1; last_resp = 3'd7; last_rd = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_v[d]) begin
        last_lat = i - 1; last_resp = resp_v[d]; last_rd = rdata_v[d];
        txn_v[d] = 1'b0;
        break;
      end
    end
    if (last_lat < 0) begin
      txn_v[d] = 1'b0;
      check("done_timeout", 64'(done_v[d]), 64'd1);
    end
  endtask

  task automatic beat_chk(input string tag, input int d, input logic [2:0] c,
                          input logic [33:0] a, input logic [31:0] wd, input logic [3:0] b,
                          input int exp_lat, input logic [2:0] exp_resp);
    beat(d, c, a, wd, b);
    check({tag, "_lat"}, 64'(last_lat), 64'(exp_lat));
    check({tag, "_resp"}, 64'(last_resp), 64'(exp_resp));
  endtask

  task automatic read_chk(input string tag, input int d, input logic [33:0] a,
                          input int exp_lat, input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    beat_chk(tag, d, RD, a, 32'h0, 4'h0, exp_lat, OK);
    check({tag, "_rdata"}, 64'(last_rd), 64'(exp_q.pop_front()));
  endtask

  logic [15:0] m_lfsr;
  logic [31:0] shadow [16];
  logic [7:0]  pattern;
  int          n_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_v = 3'b000; txn_v = 3'b000;
    cmd = 3'd0; address = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    rst_n_v = 3'b111;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_done", 64'(done_v[d]), 64'd0);
      check("rst_resp", 64'(resp_v[d]), 64'(OK));
      check("rst_rdata", 64'(rdata_v[d]), 64'd0);
      check("rst_state", 64'(st_v[d]), 64'd0);
    end

    // Fixed latency: every beat completes one cycle after acceptance.
    beat_chk("wr_full", 0, WR, 34'h100, 32'hDEADBEEF, 4'hF, 1, OK);
    @(negedge clk);
    check("done_one_cycle", 64'(done_v[0]), 64'd0);
    read_chk("rd_full", 0, 34'h100, 1, 32'hDEADBEEF);
    beat_chk("wr_part", 0, WR, 34'h100, 32'h11223344, 4'b0101, 1, OK);
    read_chk("rd_part", 0, 34'h100, 1, 32'hDE22BE44);
    beat_chk("wr_104", 0, WR, 34'h104, 32'h01020304, 4'hF, 1, OK);
    beat_chk("wr_be0", 0, WR, 34'h104, 32'hFFFFFFFF, 4'h0, 1, OK);
    read_chk("rd_be0", 0, 34'h104, 1, 32'h01020304);

    beat_chk("wr_mis", 0, WR, 34'h102, 32'h0, 4'hF, 1, MIS);
    read_chk("rd_after_mis", 0, 34'h100, 1, 32'hDE22BE44);
    beat_chk("rd_mis", 0, RD, 34'h102, 32'h0, 4'h0, 1, MIS);
    check("rd_mis_hold", 64'(last_rd), 64'h0DE22BE44);
    beat_chk("wr_idx0", 0, WR, 34'h0, 32'h00000055, 4'hF, 1, OK);
    beat_chk("wr_hi", 0, WR, 34'h1_0000_0000, 32'h99, 4'hF, 1, UNK);
    read_chk("rd_no_alias", 0, 34'h0, 1, 32'h00000055);
    beat_chk("rd_4000", 0, RD, 34'h4000, 32'h0, 4'h0, 1, UNK);
    beat_chk("wr_3ffc", 0, WR, 34'h3FFC, 32'h00000077, 4'hF, 1, OK);
    read_chk("rd_3ffc", 0, 34'h3FFC, 1, 32'h00000077);
    beat_chk("cmd7", 0, 3'b111, 34'h0, 32'h99, 4'hF, 1, INV);
    beat_chk("cmd0", 0, 3'b000, 34'h0, 32'h99, 4'hF, 1, INV);
    read_chk("rd_after_inv", 0, 34'h0, 1, 32'h00000055);
    beat_chk("prio_inv", 0, 3'b111, 34'h102, 32'h0, 4'h0, 1, INV);
    beat_chk("prio_mis", 0, RD, 34'h1_0000_0002, 32'h0, 4'h0, 1, MIS);

    // Error window covers word indices 16..19.
    read_chk("rd_pre_win", 0, 34'h100, 1, 32'hDE22BE44);
    beat_chk("rd_win", 0, RD, 34'h44, 32'h0, 4'h0, 1, UNK);
    check("rd_win_hold", 64'(last_rd), 64'h0DE22BE44);
    beat_chk("wr_win_lo", 0, WR, 34'h40, 32'h1234, 4'hF, 1, UNK);
    beat_chk("rd_win_hi", 0, RD, 34'h4C, 32'h0, 4'h0, 1, UNK);
    beat_chk("wr_below", 0, WR, 34'h3C, 32'h0000AAAA, 4'hF, 1, OK);
    beat_chk("wr_above", 0, WR, 34'h50, 32'h0000BBBB, 4'hF, 1, OK);
    read_chk("rd_below", 0, 34'h3C, 1, 32'h0000AAAA);
    read_chk("rd_above", 0, 34'h50, 1, 32'h0000BBBB);

    // Holding transaction across done cycles gives a done every other cycle.
    @(negedge clk);
    cmd = RD; address = 34'h100; be = 4'h0;
    txn_v[0] = 1'b1;
    pattern = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pattern = {pattern[6:0], done_v[0]};
    end
    txn_v[0] = 1'b0;
    check("b2b_pattern", 64'(pattern), 64'h55);
    @(negedge clk);
    check("b2b_drained", 64'(done_v[0]), 64'd0);
    @(negedge clk);

    // Default parameters: latency follows a reference LFSR, data a shadow array.
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 64; i++) begin
      logic [3:0]  idx;
      logic [31:0] wd;
      logic [3:0]  bb;
      int          el;
      el  = 1 + int'(m_lfsr[3:0]);
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      idx = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      wd  = $urandom;
      bb  = (i < 16) ? 4'hF : 4'($urandom_range(0, 15));
      if (i >= 16 && $urandom_range(0, 1) == 1) begin
        read_chk("rnd_rd", 1, {28'd0, idx, 2'b00}, el, shadow[idx]);
      end else begin
        beat_chk("rnd_wr", 1, WR, {28'd0, idx, 2'b00}, wd, bb, el, OK);
        for (int b = 0; b < 4; b++)
          if (bb[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end

    // Five wait cycles: drop during WAIT, then reset during WAIT.
    beat_chk("slow_wr", 2, WR, 34'h40, 32'h0D0D0D0D, 4'hF, 6, OK);
    read_chk("slow_rd", 2, 34'h40, 6, 32'h0D0D0D0D);
    cmd = WR; address = 34'h40; wdata = 32'h0000CCCC; be = 4'hF;
    txn_v[2] = 1'b1;
    repeat (3) @(negedge clk);
    txn_v[2] = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_v[2]) n_done++;
    end
    check("drop_no_done", 64'(n_done), 64'd0);
    check("drop_state", 64'(st_v[2]), 64'd0);
    read_chk("drop_mem", 2, 34'h40, 6, 32'h0D0D0D0D);

    cmd = WR; address = 34'h40; wdata = 32'h0000EEEE; be = 4'hF;
    txn_v[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n_v[2] = 1'b0;
    #1;
    check("mid_rst_done", 64'(done_v[2]), 64'd0);
    check("mid_rst_resp", 64'(resp_v[2]), 64'(OK));
    check("mid_rst_rdata", 64'(rdata_v[2]), 64'd0);
    check("mid_rst_state", 64'(st_v[2]), 64'd0);
    txn_v[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_v[2] = 1'b1;
    @(negedge clk);
    read_chk("rst_mem", 2, 34'h40, 6, 32'h0D0D0D0D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
